// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared FSM state encoding and read/write constants for the L2 port arbiter
package l2_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, ISSUE_LOCKED, LOCKED} state_e;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/l2_port_arbiter_if.sv
// l2_port_arbiter_if: bundle of requester-side and L2-side signals of the L2 port arbiter
//   master: arbiter view (drives req_ack, resp_*, l2_* request, err)
//   slave:  environment view (requesters + L2 model)
interface l2_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_rw;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LINE_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        resp_done;
    logic [LINE_W-1:0]         resp_rdata;
    logic                      l2_valid;
    logic                      l2_rw;
    logic [ADDR_W-1:0]         l2_addr;
    logic [LINE_W-1:0]         l2_wdata;
    logic                      l2_stall;
    logic                      l2_done;
    logic [LINE_W-1:0]         l2_rdata;
    logic                      err;
    modport master (
        input  req_valid, req_rw, req_lock, req_addr, req_wdata, l2_stall, l2_done, l2_rdata,
        output req_ack, resp_done, resp_rdata, l2_valid, l2_rw, l2_addr, l2_wdata, err
    );
    modport slave (
        output req_valid, req_rw, req_lock, req_addr, req_wdata, l2_stall, l2_done, l2_rdata,
        input  req_ack, resp_done, resp_rdata, l2_valid, l2_rw, l2_addr, l2_wdata, err
    );
endinterface

// File: rtl/l2_arb_owner_fifo.sv
// l2_arb_owner_fifo: in-order FIFO of requester ids for outstanding L2 reads
//   push_i/id_i: enqueue id; pop_i: dequeue head; full_o/empty_o: status; head_o: oldest id
module l2_arb_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] id_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] head_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign head_o  = mem_q[rp_q];
    always_comb begin
        wp_d  = push_i ? ((wp_q == AW'(DEPTH - 1)) ? '0 : wp_q + 1'b1) : wp_q;
        rp_d  = pop_i ? ((rp_q == AW'(DEPTH - 1)) ? '0 : rp_q + 1'b1) : rp_q;
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wp_q] <= id_i;
    end
endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: round-robin, lockable sharing of one L2 request port among NUM_REQ L1 controllers
//   clock/reset: sync active-high reset
//   bus (master): req_* from requesters, req_ack one-hot combinational, resp_* read completions,
//                 l2_* single-entry request register toward L2, l2_stall/l2_done/l2_rdata from L2, err sticky
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 128,
    parameter int MAX_OUT = 4
) (
    input  logic clock,
    input  logic reset,
    l2_port_arbiter_if.master bus
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d, owner_q, owner_d, win, head;
    logic [ID_W:0]       idx;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [NUM_REQ-1:0]  resp_done_q, resp_done_d;
    logic [LINE_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                err_q, err_d;
    logic [NUM_REQ-1:0]  elig, rot;
    logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
    logic [LINE_W-1:0]   wdata_a [NUM_REQ];
    logic                full_out, locked, cap_en, cap, win_lock, full_d, locked_d;
    logic                fifo_full, fifo_empty, push, pop;
    assign full_out = state_q == ISSUE || state_q == ISSUE_LOCKED;
    assign locked   = state_q == ISSUE_LOCKED || state_q == LOCKED;
    assign cap_en   = ~full_out | ~bus.l2_stall;
    // Reads need a free owner slot; a pop in the same cycle does not free one.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i]    = bus.req_valid[i] & cap_en & (~locked | owner_q == ID_W'(i))
                       & (bus.req_rw[i] == RW_WRITE | ~fifo_full);
            addr_a[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = bus.req_wdata[i*LINE_W +: LINE_W];
        end
    end
    // Rotate so bit 0 is the requester at rr_ptr, then take the first set bit.
    assign rot = NUM_REQ'({elig, elig} >> rr_ptr_q);
    always_comb begin
        cap = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!cap && rot[k]) begin
                cap = 1'b1;
                idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            end
        end
        win = ID_W'((idx >= (ID_W+1)'(NUM_REQ)) ? idx - (ID_W+1)'(NUM_REQ) : idx);
    end
    assign win_lock = bus.req_lock[win];
    assign push     = cap & (bus.req_rw[win] == RW_READ);
    assign pop      = bus.l2_done & ~fifo_empty;
    always_comb begin
        full_d       = cap | (full_out & bus.l2_stall);
        locked_d     = cap ? win_lock : locked;
        state_d      = full_d ? (locked_d ? ISSUE_LOCKED : ISSUE) : (locked_d ? LOCKED : IDLE);
        rr_ptr_d     = (cap & ~win_lock) ? ((win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1) : rr_ptr_q;
        owner_d      = (cap & win_lock) ? win : owner_q;
        rw_d         = cap ? bus.req_rw[win] : rw_q;
        addr_d       = cap ? addr_a[win] : addr_q;
        wdata_d      = cap ? wdata_a[win] : wdata_q;
        resp_done_d  = pop ? NUM_REQ'(1) << head : '0;
        resp_rdata_d = pop ? bus.l2_rdata : resp_rdata_q;
        err_d        = err_q | (bus.l2_done & fifo_empty);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_done_q  <= '0;
            resp_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_done_q  <= resp_done_d;
            resp_rdata_q <= resp_rdata_d;
            err_q        <= err_d;
        end
    end
    l2_arb_owner_fifo #(.DEPTH(MAX_OUT), .W(ID_W)) u_owner_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .id_i    (win),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head)
    );
    assign bus.req_ack    = cap ? NUM_REQ'(1) << win : '0;
    assign bus.resp_done  = resp_done_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.l2_valid   = full_out;
    assign bus.l2_rw      = rw_q;
    assign bus.l2_addr    = addr_q;
    assign bus.l2_wdata   = wdata_q;
    assign bus.err        = err_q;
endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Shares the single L2 request port between `NUM_REQ` L1 cache controllers (e.g. I-cache and D-cache), sitting between their miss/writeback FSMs and the L2. Selects one request per cycle round-robin, holds it on the L2 port until the L2 accepts it, and supports a lock so a requester's writeback and its refill read issue back-to-back. Tracks outstanding reads in an in-order owner FIFO and routes each L2 completion back to the requester that issued it.

## Interface
- `NUM_REQ`, 2: number of requesters, ≥2; `ID_W = max(1, $clog2(NUM_REQ))`.
- `ADDR_W`, 32: line address width.
- `LINE_W`, 128: cache line data width.
- `MAX_OUT`, 4: maximum outstanding reads, power of two.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester request present; held until acked.
- `req_rw` in NUM_REQ: 1 = write (writeback), 0 = read (refill).
- `req_lock` in NUM_REQ: keep grant on this requester for its next request.
- `req_addr` in NUM_REQ*ADDR_W: packed addresses, requester i at slice i.
- `req_wdata` in NUM_REQ*LINE_W: packed write data.
- `req_ack` out NUM_REQ: one-hot, combinational; request captured at this edge.
- `resp_done` out NUM_REQ: one-hot read completion pulse.
- `resp_rdata` out LINE_W: data for `resp_done`.
- `l2_valid` out 1: request on L2 port.
- `l2_rw` out 1: 1 = write.
- `l2_addr` out ADDR_W, `l2_wdata` out LINE_W: request payload.
- `l2_stall` in 1: L2 not accepting this cycle.
- `l2_done` in 1: in-order read completion.
- `l2_rdata` in LINE_W: completion data.
- `err` out 1: sticky protocol error.

## Operation
- Output register holds at most one request. Accept = `l2_valid & ~l2_stall`. `cap_en = ~l2_valid | ~l2_stall`.
- Eligible requester i: `req_valid[i]`, `cap_en`, not locked to another requester; reads also need owner FIFO not full (no same-cycle pop bypass).
- Winner = first eligible at or after priority pointer `rr_ptr`. `req_ack[winner]`=1; payload captured at the edge; read pushes winner id into owner FIFO at the same edge.
- After a capture with `req_lock`=0, `rr_ptr = (winner+1) mod NUM_REQ`, and lock is cleared. With `req_lock`=1, `rr_ptr` is unchanged and the lock owner = winner. Only the owner is eligible until it is captured with `req_lock`=0.
- FSM states:
  - IDLE: output empty, unlocked.
  - ISSUE: output full, unlocked.
  - ISSUE_LOCKED: output full, locked.
  - LOCKED: output empty, locked.
- FSM transitions: capture → ISSUE or ISSUE_LOCKED, according to the captured `req_lock`. Accept without a new capture → IDLE or LOCKED. Accept with a new capture in the same cycle → ISSUE* again, with no bubble.
- Writes complete on accept and produce no `resp_done`.
- `l2_done`: pop the FIFO head; next cycle `resp_done[head]`=1 and `resp_rdata` = captured `l2_rdata`. Push and pop in the same cycle are allowed; occupancy is unchanged.
- `l2_done` with the FIFO empty sets `err`, produces no `resp_done`, and leaves state unchanged. `err` clears only on reset.

## Timing
- Reset values: all outputs 0, `rr_ptr`=0, FIFO empty, state IDLE, lock cleared.
- Request to `l2_valid`: 1 cycle (ack in cycle t, `l2_valid` from t+1).
- `l2_valid` and its payload stay stable until accepted.
- `l2_done` to `resp_done`: 1 cycle; `resp_done` is a single-cycle pulse.
- Sustained throughput: 1 request/cycle while `l2_stall`=0.
- Reset mid-operation: in-flight request and FIFO contents are dropped. The L2 must be reset in the same cycle.

## Structure
- Package `l2_arb_pkg`: FSM state enum (IDLE, ISSUE, ISSUE_LOCKED, LOCKED), `RW_READ`/`RW_WRITE` constants.
- Sub-module `l2_arb_owner_fifo`: MAX_OUT×ID_W synchronous FIFO with push, pop, full, empty, head.
- Arbitration, FSM, and output register stay in the top level.

## Test plan
- Req0 read 0x100 in cycle 0, `l2_stall`=0 → `req_ack`=01 in cycle 0, `l2_valid`/addr 0x100 in cycle 1. `l2_done`+data 0xAB in cycle 5 → `resp_done`=01, `resp_rdata`=0xAB in cycle 6.
- Both requesters read continuously, no stall → acks alternate 01,10,01,10; `l2_addr` alternates accordingly.
- Req1 write with lock, then read; req0 requesting throughout → req1 write and req1 read are issued consecutively, req0 is acked only after the read is captured.
- `l2_stall`=1 for 3 cycles with req0 write pending → `l2_valid`/payload stable for 4 cycles, no further ack until the accept cycle.
- MAX_OUT=4 reads outstanding, req0 requests a 5th read → no ack. On `l2_done`, ack on the following cycle; completions return to the owners in issue order.
- `l2_done` with no outstanding read → `err`=1 next cycle, no `resp_done`; `err` stays 1 until reset.
